// File: rtl/dest_reg_scoreboard.sv
// Tracks decode's destination-register write through the EX/MEM/WB slots.
// Produces pending-write masks, the WB register-file write enable and the RAW stall request.
module dest_reg_scoreboard #(
  parameter int REG_W     = 3,
  parameter int WB_BYPASS = 1,
  localparam int NUM_REGS = 2 ** REG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_wr_en,
  input  logic [REG_W-1:0]    id_dst_reg,
  input  logic [REG_W-1:0]    id_src1,
  input  logic                id_src1_use,
  input  logic [REG_W-1:0]    id_src2,
  input  logic                id_src2_use,
  input  logic                stall,
  input  logic                flush,
  output logic                ex_valid,
  output logic                mem_valid,
  output logic                wb_valid,
  output logic [REG_W-1:0]    ex_dst,
  output logic [REG_W-1:0]    mem_dst,
  output logic [REG_W-1:0]    wb_dst,
  output logic [NUM_REGS-1:0] pending,
  output logic [NUM_REGS-1:0] wb_we,
  output logic                hazard
);

  logic             ex_valid_q, ex_valid_d;
  logic             mem_valid_q, mem_valid_d;
  logic             wb_valid_q, wb_valid_d;
  logic [REG_W-1:0] ex_dst_q, ex_dst_d;
  logic [REG_W-1:0] mem_dst_q, mem_dst_d;
  logic [REG_W-1:0] wb_dst_q, wb_dst_d;

  // Flush squashes both the decode entry and the one already in EX.
  always_comb begin
    ex_valid_d  = id_wr_en & ~stall & ~flush;
    ex_dst_d    = id_dst_reg;
    mem_valid_d = ex_valid_q & ~flush;
    mem_dst_d   = ex_dst_q;
    wb_valid_d  = mem_valid_q;
    wb_dst_d    = mem_dst_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      ex_dst_q    <= '0;
      mem_dst_q   <= '0;
      wb_dst_q    <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
      ex_dst_q    <= ex_dst_d;
      mem_dst_q   <= mem_dst_d;
      wb_dst_q    <= wb_dst_d;
    end
  end

  logic [NUM_REGS-1:0] ex_hit, mem_hit, wb_hit;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign ex_hit[gi]  = ex_valid_q  && (ex_dst_q  == REG_W'(gi));
      assign mem_hit[gi] = mem_valid_q && (mem_dst_q == REG_W'(gi));
      assign wb_hit[gi]  = wb_valid_q  && (wb_dst_q  == REG_W'(gi));
    end
  endgenerate

  // With a write-before-read register file the WB slot never needs a stall.
  logic [NUM_REGS-1:0] haz_mask;
  assign haz_mask = ex_hit | mem_hit | ((WB_BYPASS != 0) ? '0 : wb_hit);

  assign pending   = ex_hit | mem_hit | wb_hit;
  assign wb_we     = wb_hit;
  assign hazard    = (id_src1_use & haz_mask[id_src1]) | (id_src2_use & haz_mask[id_src2]);
  assign ex_valid  = ex_valid_q;
  assign mem_valid = mem_valid_q;
  assign wb_valid  = wb_valid_q;
  assign ex_dst    = ex_dst_q;
  assign mem_dst   = mem_dst_q;
  assign wb_dst    = wb_dst_q;

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Queue-scoreboard bench for dest_reg_scoreboard; both WB_BYPASS settings run on shared stimulus.
module tb_dest_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_wr_en = 1'b0;
  logic [2:0] id_dst_reg = '0;
  logic [2:0] id_src1 = '0;
  logic       id_src1_use = 1'b0;
  logic [2:0] id_src2 = '0;
  logic       id_src2_use = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;

  logic       ex_v1, mem_v1, wb_v1, haz1;
  logic [2:0] ex_d1, mem_d1, wb_d1;
  logic [7:0] pend1, we1;
  logic       ex_v0, mem_v0, wb_v0, haz0;
  logic [2:0] ex_d0, mem_d0, wb_d0;
  logic [7:0] pend0, we0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dest_reg_scoreboard #(.REG_W(3), .WB_BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_wr_en(id_wr_en), .id_dst_reg(id_dst_reg),
    .id_src1(id_src1), .id_src1_use(id_src1_use), .id_src2(id_src2), .id_src2_use(id_src2_use),
    .stall(stall), .flush(flush),
    .ex_valid(ex_v1), .mem_valid(mem_v1), .wb_valid(wb_v1),
    .ex_dst(ex_d1), .mem_dst(mem_d1), .wb_dst(wb_d1),
    .pending(pend1), .wb_we(we1), .hazard(haz1));

  dest_reg_scoreboard #(.REG_W(3), .WB_BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_wr_en(id_wr_en), .id_dst_reg(id_dst_reg),
    .id_src1(id_src1), .id_src1_use(id_src1_use), .id_src2(id_src2), .id_src2_use(id_src2_use),
    .stall(stall), .flush(flush),
    .ex_valid(ex_v0), .mem_valid(mem_v0), .wb_valid(wb_v0),
    .ex_dst(ex_d0), .mem_dst(mem_d0), .wb_dst(wb_d0),
    .pending(pend0), .wb_we(we0), .hazard(haz0));

  // Reference: a list of in-flight writes, each with its age since acceptance.
  typedef struct {
    int         age;
    logic [2:0] dst;
  } ent_t;
  ent_t inflight[$];

  typedef struct packed {
    logic       ex_v, mem_v, wb_v;
    logic [2:0] ex_d, mem_d, wb_d;
    logic [7:0] pend, we;
    logic       haz1, haz0;
  } exp_t;
  exp_t exp_q[$];
  bit   known = 0;

  function automatic exp_t predict();
    exp_t e;
    e = '0;
    foreach (inflight[k]) begin
      e.pend[inflight[k].dst] = 1'b1;
      case (inflight[k].age)
        0: begin e.ex_v = 1'b1;  e.ex_d = inflight[k].dst; end
        1: begin e.mem_v = 1'b1; e.mem_d = inflight[k].dst; end
        default: begin
          e.wb_v = 1'b1; e.wb_d = inflight[k].dst;
          e.we[inflight[k].dst] = 1'b1;
        end
      endcase
      if ((id_src1_use && id_src1 == inflight[k].dst) || (id_src2_use && id_src2 == inflight[k].dst)) begin
        if (inflight[k].age < 2) e.haz1 = 1'b1;
        e.haz0 = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    ent_t nq[$];
    if (!rst_n) begin
      inflight.delete();
      known = 1;
      return;
    end
    foreach (inflight[k]) begin
      ent_t e;
      e = inflight[k];
      if (!(flush && e.age == 0) && e.age < 2) begin
        e.age++;
        nq.push_back(e);
      end
    end
    if (!flush && !stall && id_wr_en) nq.push_back('{age: 0, dst: id_dst_reg});
    inflight = nq;
  endtask

  task automatic cycle();
    if (known) exp_q.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: every sampled cycle with a pushed expectation is compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_valid1", ex_v1, e.ex_v);   chk("ex_valid0", ex_v0, e.ex_v);
        chk("mem_valid1", mem_v1, e.mem_v); chk("mem_valid0", mem_v0, e.mem_v);
        chk("wb_valid1", wb_v1, e.wb_v);   chk("wb_valid0", wb_v0, e.wb_v);
        if (e.ex_v)  begin chk("ex_dst1", ex_d1, e.ex_d);   chk("ex_dst0", ex_d0, e.ex_d); end
        if (e.mem_v) begin chk("mem_dst1", mem_d1, e.mem_d); chk("mem_dst0", mem_d0, e.mem_d); end
        if (e.wb_v)  begin chk("wb_dst1", wb_d1, e.wb_d);   chk("wb_dst0", wb_d0, e.wb_d); end
        chk("pending1", pend1, e.pend);    chk("pending0", pend0, e.pend);
        chk("wb_we1", we1, e.we);          chk("wb_we0", we0, e.we);
        chk("hazard_bypass1", haz1, e.haz1);
        chk("hazard_bypass0", haz0, e.haz0);
      end
    end
  end

  task automatic idle();
    id_wr_en = 0; id_src1_use = 0; id_src2_use = 0; stall = 0; flush = 0;
  endtask

  task automatic issue(input logic [2:0] d);
    idle(); id_wr_en = 1; id_dst_reg = d; cycle();
  endtask

  // Dependent instruction on register 3 held in decode with stall driven from one DUT's hazard.
  task automatic dependent(input bit use_b1, output int n);
    n = 0;
    issue(3'd3);
    for (int i = 0; i < 8; i++) begin
      idle(); id_wr_en = 1; id_dst_reg = 3'd5; id_src1 = 3'd3; id_src1_use = 1;
      #1;
      stall = use_b1 ? haz1 : haz0;
      if (stall) n++;
      cycle();
      if (!stall) break;
    end
    idle();
    repeat (4) cycle();
  endtask

  initial begin
    int n;
    idle();
    rst_n = 0;
    repeat (2) cycle();
    rst_n = 1;
    repeat (2) cycle();

    issue(3'd5);
    idle();
    repeat (4) cycle();

    dependent(1'b1, n);
    chk("hazard_cycles_bypass1", n, 2);
    dependent(1'b0, n);
    chk("hazard_cycles_bypass0", n, 3);

    // Flush alone, then stall+flush together.
    for (int m = 0; m < 2; m++) begin
      issue(3'd2);
      idle(); id_wr_en = 1; id_dst_reg = 3'd6; flush = 1; stall = (m == 1);
      cycle();
      idle();
      repeat (4) cycle();
      chk("pending_after_flush", pend1, 0);
    end

    issue(3'd1); issue(3'd4); issue(3'd7);
    idle(); rst_n = 0; cycle();
    rst_n = 1; cycle();
    chk("pending_after_reset", pend1, 0);

    for (int i = 0; i < 600; i++) begin
      rst_n       = ($urandom_range(59, 0) != 0);
      id_wr_en    = ($urandom_range(3, 0) != 0);
      id_dst_reg  = 3'($urandom_range(7, 0));
      id_src1     = 3'($urandom_range(7, 0));
      id_src2     = 3'($urandom_range(7, 0));
      id_src1_use = $urandom_range(1, 0) != 0;
      id_src2_use = $urandom_range(1, 0) != 0;
      flush       = ($urandom_range(9, 0) == 0);
      #1;
      case ($urandom_range(2, 0))
        0: stall = haz1;
        1: stall = haz0;
        default: stall = ($urandom_range(4, 0) == 0);
      endcase
      cycle();
    end

    idle();
    repeat (4) cycle();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dest_reg_scoreboard.md
Name: dest_reg_scoreboard

Overview:
- Consumer end of the destination-register selection path. It takes the 3-bit write-register specifier chosen in decode and tracks it through the EX, MEM and WB slots.
- In WB it decodes the specifier into one-hot register-file write enables.
- From the in-flight slots it generates the RAW hazard (stall request) for decode-stage source registers.
- Sits beside the decode/hazard unit of the 5-stage pipeline.

Parameters:
- REG_W, 3, register-specifier width; NUM_REGS = 2**REG_W.
- WB_BYPASS, 1, 1 = register file writes before it reads, so the WB slot is excluded from hazard compare; 0 = WB slot included.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_wr_en  in  1  decode instruction writes a register.
- id_dst_reg  in  REG_W  decode destination specifier (output of the destination select mux).
- id_src1  in  REG_W  decode source 1 specifier.
- id_src1_use  in  1  source 1 is read.
- id_src2  in  REG_W  decode source 2 specifier.
- id_src2_use  in  1  source 2 is read.
- stall  in  1  decode held; bubble into EX.
- flush  in  1  squash decode and EX instructions.
- ex_valid, mem_valid, wb_valid  out  1 each  slot holds a pending write.
- ex_dst, mem_dst, wb_dst  out  REG_W each  slot destination.
- pending  out  NUM_REGS  bit r set if any valid slot targets r.
- wb_we  out  NUM_REGS  one-hot register-file write enable for the WB slot.
- hazard  out  1  RAW hazard on a used decode source.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all valid bits and dst fields to 0. After reset, pending=0, wb_we=0 and hazard=0. Reset overrides stall and flush.
- Each edge, the slots shift as a 3-deep shift register: WB<=MEM, MEM<=EX, EX<=ID. MEM and WB always advance; there is no back-pressure on them.
- EX load is a priority decision:
  - flush=1 -> EX.valid=0 and MEM.valid=0. The squashed EX entry never reaches MEM. WB<=old MEM as normal.
  - else stall=1 -> EX.valid=0 (bubble); MEM<=old EX.
  - else EX.valid<=id_wr_en and EX.dst<=id_dst_reg.
- stall and flush both high -> flush behaviour.
- dst fields load even when the slot is invalid. Consumers must gate every dst field with its valid bit.
- Invalid slots contribute nothing to pending, wb_we or hazard.
- pending: bitwise OR of the one-hot decodes of the EX, MEM and WB slots. Purely combinational from registers.
- wb_we: one-hot of wb_dst when wb_valid, else all-zero. Exactly 0 or 1 bit is set.
- hazard = (id_src1_use & match(id_src1)) | (id_src2_use & match(id_src2)).
  - match(s) = (ex_valid & ex_dst==s) | (mem_valid & mem_dst==s) | (!WB_BYPASS & wb_valid & wb_dst==s).
  - Combinational, same cycle; decode logic drives stall from it.
- Latency: a destination accepted at edge N is in EX after N, MEM after N+1, WB after N+2. It leaves the scoreboard after edge N+3.
- Hazard lifetime for WB_BYPASS=1: a back-to-back dependent instruction sees hazard for exactly 2 cycles while stalled, then proceeds.
- A repeated destination across slots is legal. pending still shows one bit, and the bit stays set until the last matching slot retires.
- All registers are on clk only; no async paths.

Test Plan:
- Reset and idle: rst_n=0 for 2 cycles, then idle -> all valid=0, pending=0x00, wb_we=0x00, hazard=0.
- Issue then retire: one cycle id_wr_en=1, id_dst_reg=5 ->
  - pending=0x20 after edges 1-3;
  - wb_we=0x20 only after edge 3;
  - all zero after edge 4.
- Dependent instruction with WB_BYPASS=1: issue dst=3, then hold id_src1=3, id_src1_use=1 with stall=hazard ->
  - hazard=1 for 2 cycles, 0 once the write reaches WB;
  - bubbles appear in EX while stalled.
- Same sequence with WB_BYPASS=0 -> hazard=1 for 3 cycles.
- Flush: dst=2 in EX and dst=6 in ID, assert flush for one edge ->
  - MEM.valid=0 and EX.valid=0;
  - register 2 never appears in wb_we; pending=0x00 once prior slots drain.
- Stall+flush together, and reset mid-flight: three writes 1, 4, 7 in flight, then rst_n=0 one edge -> all valid=0 and pending=0x00 on the next cycle. The stall+flush case must equal flush alone.
